// File: rtl/spart_fifo_driver.sv
// Byte FIFO that buffers SPART receive data for retransmission; one push or pop per cycle.
// Level is registered; the driver never pushes when full or pops when empty.
module spart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// SPART bus master: programs the baud divisor, then loops received bytes back out through a FIFO.
// Each bus transaction is one cycle followed by IDLE; a full FIFO leaves bytes in the SPART.
module spart_fifo_driver #(
  parameter int CLK_HZ = 100000000,
  parameter int DEPTH  = 8,
  parameter int LW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    br_cfg,
  input  logic          upcase,
  input  logic          rda,
  input  logic          tbr,
  output logic          iocs,
  output logic          iorw,
  output logic [1:0]    ioaddr,
  inout  wire  [7:0]    databus,
  output logic [LW-1:0] fifo_level,
  output logic          cfg_busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_CFG_LO,
    S_CFG_HI,
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  state_t      state;
  state_t      state_n;
  logic [1:0]  br_meta;
  logic [1:0]  cfg_s;
  logic [1:0]  cfg_prog;
  logic        load_cfg;
  logic        last_rd;
  logic [15:0] divisor;
  logic        bus_oe;
  logic [7:0]  bus_dout;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  head_dat;
  logic [7:0]  tx_dat;
  logic        fifo_full;
  logic        fifo_empty;
  logic        rd_ok;
  logic        wr_ok;

  spart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (8),
    .LW    (LW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (databus),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_meta <= 2'b00;
      cfg_s   <= 2'b00;
    end else begin
      br_meta <= br_cfg;
      cfg_s   <= br_meta;
    end
  end

  always_comb begin
    case (cfg_prog)
      2'b00:   divisor = DIV_4800;
      2'b01:   divisor = DIV_9600;
      2'b10:   divisor = DIV_19200;
      default: divisor = DIV_38400;
    endcase
  end

  assign tx_dat = (upcase && head_dat >= 8'h61 && head_dat <= 8'h7A) ? head_dat - 8'h20 : head_dat;
  assign rd_ok  = rda && !fifo_full;
  assign wr_ok  = tbr && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      cfg_prog <= 2'b00;
      last_rd  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_cfg) cfg_prog <= cfg_s;
      if (state == S_RD) last_rd <= 1'b1;
      else if (state == S_WR) last_rd <= 1'b0;
    end
  end

  always_comb begin
    state_n   = state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    bus_oe    = 1'b0;
    bus_dout  = 8'h00;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    load_cfg  = 1'b0;
    case (state)
      S_INIT: begin
        load_cfg = 1'b1;
        state_n  = S_CFG_LO;
      end
      S_CFG_LO: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'b10;
        bus_oe   = 1'b1;
        bus_dout = divisor[7:0];
        state_n  = S_CFG_HI;
      end
      S_CFG_HI: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'b11;
        bus_oe   = 1'b1;
        bus_dout = divisor[15:8];
        state_n  = S_IDLE;
      end
      S_IDLE: begin
        // Reprogramming beats data; on a tie the direction not taken last time wins.
        if (cfg_s != cfg_prog) begin
          load_cfg = 1'b1;
          state_n  = S_CFG_LO;
        end else if (rd_ok && wr_ok) begin
          state_n = last_rd ? S_WR : S_RD;
        end else if (rd_ok) begin
          state_n = S_RD;
        end else if (wr_ok) begin
          state_n = S_WR;
        end
      end
      S_RD: begin
        iocs      = 1'b1;
        fifo_push = 1'b1;
        state_n   = S_IDLE;
      end
      S_WR: begin
        iocs     = 1'b1;
        iorw     = 1'b0;
        bus_oe   = 1'b1;
        bus_dout = tx_dat;
        fifo_pop = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_INIT;
    endcase
  end

  assign cfg_busy = (state == S_INIT) || (state == S_CFG_LO) || (state == S_CFG_HI);
  assign databus  = bus_oe ? bus_dout : 8'hzz;

endmodule

// File: tb/tb_spart_fifo_driver.sv
// Bench for spart_fifo_driver: acts as the SPART and checks against a queue-based byte model.
module tb_spart_fifo_driver;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int EV_NONE = 0, EV_RD = 1, EV_WR = 2, EV_CLO = 3, EV_CHI = 4, EV_BAD = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    br_cfg;
  logic          upcase;
  logic          rda;
  logic          tbr;
  logic          iocs;
  logic          iorw;
  logic [1:0]    ioaddr;
  wire  [7:0]    databus;
  logic [LW-1:0] fifo_level;
  logic          cfg_busy;
  logic [7:0]    drive_dat;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int ev = EV_NONE;
  int prev_ev = EV_NONE;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] model_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] sent[$];

  spart_fifo_driver #(.CLK_HZ(100000000), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .upcase     (upcase),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .fifo_level (fifo_level),
    .cfg_busy   (cfg_busy)
  );

  assign databus = (iocs && iorw) ? drive_dat : 8'hzz;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    int baud;
    baud = 4800 << sel;
    return 16'(100000000 / (16 * baud) - 1);
  endfunction

  function automatic logic [7:0] xf(input logic [7:0] b, input logic up);
    if (up && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // One clock: observe the bus at the falling edge, update the model, refresh rda.
  task automatic step();
    logic [15:0] d;
    logic [7:0]  b;
    @(negedge clk);
    cyc_n++;
    prev_ev = ev;
    ev = EV_NONE;
    if (!rst) begin
      check("level", 32'(fifo_level), model_q.size());
      if (iocs) begin
        if (ioaddr == 2'b00 && iorw) ev = EV_RD;
        else if (ioaddr == 2'b00) ev = EV_WR;
        else if (!iorw && ioaddr == 2'b10) ev = EV_CLO;
        else if (!iorw && ioaddr == 2'b11) ev = EV_CHI;
        else ev = EV_BAD;
      end
      if (prev_ev == EV_CLO) check("cfg_pair", ev, EV_CHI);
      d = div_of(br_cfg);
      case (ev)
        EV_RD: begin
          check("rd_room", model_q.size() < DEPTH, 1);
          check("rd_rda", 32'(rda), 1);
          if (rx_q.size() > 0) begin
            b = rx_q.pop_front();
            model_q.push_back(b);
          end
          rd_cnt++;
          rd_cyc = cyc_n;
        end
        EV_WR: begin
          check("wr_tbr", 32'(tbr), 1);
          check("wr_nonempty", model_q.size() > 0, 1);
          if (model_q.size() > 0) begin
            b = model_q.pop_front();
            check("wr_dat", 32'(databus), 32'(xf(b, upcase)));
          end
          tx_log.push_back(databus);
          wr_cnt++;
          wr_cyc = cyc_n;
        end
        EV_CLO: begin
          check("cfg_lo_dat", 32'(databus), 32'(d & 16'h00FF));
          check("cfg_lo_busy", 32'(cfg_busy), 1);
        end
        EV_CHI: begin
          check("cfg_hi_dat", 32'(databus), 32'(d >> 8));
          check("cfg_hi_busy", 32'(cfg_busy), 1);
        end
        EV_BAD: check("bus_op", {29'd0, iorw, ioaddr}, 0);
        default: ;
      endcase
      rda = (rx_q.size() > 0);
      if (ev != EV_RD && rx_q.size() > 0) drive_dat = rx_q[0];
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_q.push_back(b);
    rda = 1'b1;
    if (rx_q.size() == 1 && ev != EV_RD) drive_dat = b;
  endtask

  task automatic wait_cfg(input string tag, input logic [7:0] lo, input logic [7:0] hi, input int max);
    int found = 0;
    int ndata = 0;
    for (int i = 0; i < max && found == 0; i++) begin
      step();
      if (ev == EV_CLO) found = 1;
      else if (ev == EV_RD || ev == EV_WR) ndata++;
    end
    check({tag, "_seen"}, found, 1);
    check({tag, "_nodata"}, ndata, 0);
    if (found == 1) begin
      check({tag, "_lo"}, 32'(databus), 32'(lo));
      step();
      check({tag, "_hi_ev"}, ev, EV_CHI);
      check({tag, "_hi"}, 32'(databus), 32'(hi));
      step();
      check({tag, "_busy_done"}, 32'(cfg_busy), 0);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    tbr = 1'b1;
    while ((model_q.size() > 0 || rx_q.size() > 0) && n < 300) begin
      step();
      n++;
    end
    step();
    check({tag, "_drained"}, model_q.size() + rx_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt0;
    int c0;
    int prev_data;
    logic [7:0] b;

    rst = 1'b1; br_cfg = 2'b00; upcase = 1'b0; rda = 1'b0; tbr = 1'b0; drive_dat = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_iocs", 32'(iocs), 0);
    check("rst_iorw", 32'(iorw), 1);
    check("rst_ioaddr", 32'(ioaddr), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_busy", 32'(cfg_busy), 1);
    rst = 1'b0;
    wait_cfg("boot", 8'h15, 8'h05, 3);

    // Baud change while idle: reprogram within four cycles.
    br_cfg = 2'b11;
    wait_cfg("br11", 8'hA1, 8'h00, 4);
    br_cfg = 2'b00;
    wait_cfg("br00", 8'h15, 8'h05, 4);

    // Fill past capacity with transmit blocked.
    tbr = 1'b0; tx_log.delete(); sent.delete();
    cnt0 = rd_cnt;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      rx_push(b);
    end
    repeat (2 * DEPTH + 6) step();
    check("full_reads", rd_cnt - cnt0, DEPTH);
    check("full_level", 32'(fifo_level), DEPTH);
    check("full_pending", rx_q.size(), 1);
    drain("full");
    check("full_txcnt", tx_log.size(), DEPTH + 1);
    for (int i = 0; i < tx_log.size() && i < sent.size(); i++) check("full_order", 32'(tx_log[i]), 32'(sent[i]));

    // Minimum loopback latency and upper-casing.
    upcase = 1'b1; tbr = 1'b1; tx_log.delete();
    c0 = cyc_n;
    rx_push(8'h61);
    n = 0;
    while (tx_log.size() == 0 && n < 20) begin step(); n++; end
    check("lat_rd", rd_cyc - c0, 1);
    check("lat_wr", wr_cyc - rd_cyc, 2);
    rx_push(8'h7A); rx_push(8'h41); rx_push(8'h7B);
    drain("upc");
    check("upc_cnt", tx_log.size(), 4);
    if (tx_log.size() == 4) begin
      check("upc0", 32'(tx_log[0]), 32'h41);
      check("upc1", 32'(tx_log[1]), 32'h5A);
      check("upc2", 32'(tx_log[2]), 32'h41);
      check("upc3", 32'(tx_log[3]), 32'h7B);
    end
    upcase = 1'b0;

    // Half-full with both sides eligible: strict alternation.
    tbr = 1'b0;
    for (int i = 0; i < DEPTH / 2; i++) rx_push(8'($urandom_range(0, 255)));
    repeat (DEPTH + 4) step();
    tbr = 1'b1;
    for (int i = 0; i < 20; i++) rx_push(8'($urandom_range(0, 255)));
    n = 0; cnt0 = 0; prev_data = EV_NONE;
    while (cnt0 < 16 && n < 100) begin
      step();
      n++;
      check("alt_level", (32'(fifo_level) >= DEPTH / 2 - 1) && (32'(fifo_level) <= DEPTH / 2 + 1), 1);
      if (ev == EV_RD || ev == EV_WR) begin
        if (cnt0 == 0) check("alt_first", ev, EV_WR);
        else check("alt", ev != prev_data, 1);
        prev_data = ev;
        cnt0++;
      end
    end
    check("alt_count", cnt0, 16);
    drain("alt");

    // Random traffic with occasional baud changes.
    for (int seg = 0; seg < 6; seg++) begin
      br_cfg = 2'($urandom_range(0, 3));
      upcase = 1'($urandom_range(0, 1));
      repeat (250) begin
        step();
        tbr = ($urandom_range(0, 9) < 7);
        if (rx_q.size() < 3 && $urandom_range(0, 9) < 3)
          rx_push(($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h40, 8'h7F)) : 8'($urandom_range(0, 255)));
      end
    end
    drain("rand");
    check("rand_balance", rd_cnt, wr_cnt);
    br_cfg = 2'b00;
    repeat (6) step();

    // Reset in the middle of a write.
    tbr = 1'b0;
    for (int i = 0; i < 3; i++) rx_push(8'($urandom_range(0, 255)));
    repeat (10) step();
    tbr = 1'b1;
    n = 0;
    while (ev != EV_WR && n < 20) begin step(); n++; end
    check("rstwr_seen", ev, EV_WR);
    rst = 1'b1;
    #1;
    check("rstwr_iocs", 32'(iocs), 0);
    check("rstwr_iorw", 32'(iorw), 1);
    check("rstwr_level", 32'(fifo_level), 0);
    check("rstwr_busy", 32'(cfg_busy), 1);
    model_q.delete(); rx_q.delete(); rda = 1'b0; tbr = 1'b0;
    step();
    rst = 1'b0;
    wait_cfg("reboot", 8'h15, 8'h05, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_fifo_driver.md
SPART_FIFO_DRIVER -- requirements
Module: spart_fifo_driver

Interface
REQ-001 Parameter CLK_HZ, default 100000000: system clock frequency in Hz, used for the divisor calculation.
REQ-002 Parameter DEPTH, default 8: receive-to-transmit FIFO depth in bytes; power of two, range 2..64.
REQ-003 Parameter LW, default $clog2(DEPTH)+1: width of fifo_level.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400; asynchronous to clk.
REQ-007 upcase  input  1  1 = convert 'a'..'z' to upper case on transmit; sampled at WR.
REQ-008 rda  input  1  SPART received data available.
REQ-009 tbr  input  1  SPART transmit buffer ready.
REQ-010 iocs  output  1  SPART chip select; high only during a bus transaction.
REQ-011 iorw  output  1  1 = read, 0 = write.
REQ-012 ioaddr  output  2  00=data, 10=divisor low, 11=divisor high.
REQ-013 databus  inout  8  SPART data bus; driven only when iocs=1 and iorw=0, else high-Z.
REQ-014 fifo_level  output  LW  bytes currently buffered, 0..DEPTH.
REQ-015 cfg_busy  output  1  high from reset or br_cfg change until CFG_HI completes.

Function
REQ-016 States SHALL be INIT, CFG_LO, CFG_HI, IDLE, RD, WR; exactly one state is active per cycle.
REQ-017 IDLE and INIT SHALL decode outputs as iocs=0, iorw=1, ioaddr=00.
REQ-018 br_cfg SHALL pass through a 2-flop synchroniser; the synchronised value is cfg_s.
REQ-019 Divisor SHALL be floor(CLK_HZ/(16*baud))-1, truncated to 16 bits; default values are 1301, 650, 324, 161.
REQ-020 INIT SHALL last one cycle, latch cfg_s into cfg_prog, then go to CFG_LO.
REQ-021 CFG_LO SHALL drive iocs=1, iorw=0, ioaddr=10, databus=divisor[7:0], then go to CFG_HI.
REQ-022 CFG_HI SHALL drive iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8], then go to IDLE.
REQ-023 IDLE arbitration priority:
  - (a) cfg_s != cfg_prog -> latch cfg_s into cfg_prog, go to CFG_LO.
  - (b) read eligible: rda=1 and FIFO not full.
  - (c) write eligible: tbr=1 and FIFO not empty.
  - (d) otherwise remain in IDLE.
REQ-024 When both read and write are eligible, the FIFO shall take the one not taken by the previous data transaction (round-robin); after reset, read wins first.
REQ-025 RD SHALL drive iocs=1, iorw=1, ioaddr=00, push the databus value into the FIFO at the end of the cycle, then go to IDLE.
REQ-026 WR SHALL drive iocs=1, iorw=0, ioaddr=00, drive the FIFO head onto databus, pop the FIFO at the end of the cycle, then go to IDLE.
REQ-027 WR data with upcase=1 and head in 0x61..0x7A SHALL be head-0x20; all other data SHALL be head unmodified.
REQ-028 FIFO full with rda=1: the byte SHALL be left in the SPART (no read), with no drop and no corruption.
REQ-029 FIFO SHALL preserve byte order; pointers SHALL wrap modulo DEPTH; fifo_level SHALL change by at most 1 per cycle.
REQ-030 A br_cfg change during RD/WR SHALL not abort the transaction; reprogramming starts from the next IDLE, and FIFO contents are retained.
REQ-031 Minimum latency: rda high in IDLE cycle n -> RD in n+1 -> WR no earlier than n+3, given tbr=1 and an otherwise empty FIFO.
REQ-032 cfg_busy SHALL be 1 in INIT, CFG_LO and CFG_HI, and 0 otherwise.

Reset
REQ-033 With rst=1 the block SHALL hold:
  - state INIT
  - iocs=0, iorw=1, ioaddr=00, databus high-Z
  - FIFO empty, fifo_level=0
  - cfg_busy=1
  - round-robin pointer set to read-first
REQ-034 Reset asserted mid-transaction SHALL take effect immediately; any partial FIFO push or pop is discarded.
REQ-035 After rst deasserts, the CFG_LO/CFG_HI pair SHALL be issued before any data transaction.

Verification
REQ-036 Reset release, br_cfg=00 -> write 0x15 to addr 10, then 0x05 to addr 11 on consecutive cycles; cfg_busy falls after CFG_HI.
REQ-037 Change br_cfg 00->11 while idle -> within 4 cycles, writes of 0xA1 to addr 10 and 0x00 to addr 11 occur, with no data transaction in between.
REQ-038 tbr=0, send DEPTH+1 bytes via rda -> exactly DEPTH reads; fifo_level=DEPTH; rda stays high; then tbr=1 -> bytes are transmitted in order and the pending byte is read.
REQ-039 upcase=1, receive 0x61, 0x7A, 0x41, 0x7B -> transmit 0x41, 0x5A, 0x41, 0x7B.
REQ-040 rda and tbr held high with FIFO half-full -> transactions alternate RD, WR, RD, WR, and fifo_level stays constant ±1.
REQ-041 Assert rst during WR -> iocs=0 and databus high-Z in the same cycle; fifo_level=0; the config sequence repeats after release.
